chrono_lap_core: RTL and testbench

Parametrised stopwatch core with lap/split capture. It conditions two push-buttons, start/stop and lap/clear. It runs a BCD cascade HH:MM:SS.cc from a configurable clock frequency and presents either the live time or a frozen split on `value` for the existing `display_ctrl`. It replaces the fixed-frequency, single-button stopwatch logic at the top of the design.

---
 rtl/chrono_pkg.sv | 13 +
 rtl/btn_conditioner.sv | 45 ++++
 rtl/chrono_lap_core.sv | 111 +++++++++++
 tb/tb_chrono_lap_core.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/chrono_pkg.sv
// chrono_pkg: shared BCD time types, digit limits, run states and a counter-width helper
package chrono_pkg;
    typedef logic [3:0] bcd_t;
    typedef bcd_t [7:0] chrono_t;
    // Written from digit 7 (tens of hours) down to digit 0 (hundredths)
    localparam chrono_t DIGIT_LIMIT = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
    localparam logic [0:0] ST_STOPPED = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;
    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise and debounce one raw button, pulse on release
// Ports: clk, rst (sync, active-high), btn (raw async), level (debounced), released (1-cycle pulse on debounced fall)
module btn_conditioner
    import chrono_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic released
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;
    // The count only advances while the synchronised sample disagrees with the accepted level,
    // so any bounce back to the current level restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= btn;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign level    = r_level;
    assign released = r_level_d & ~r_level;
endmodule

// File: rtl/chrono_lap_core.sv
// chrono_lap_core: stopwatch HH:MM:SS.cc with start/stop, lap freeze and clear
// Ports: clk, rst (sync, active-high), btn_start/btn_lap (raw buttons),
//        value (BCD digits, [0]=hundredths), running, frozen, overflow (sticky), ready
module chrono_lap_core
    import chrono_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    btn_start,
    input  logic    btn_lap,
    output chrono_t value,
    output logic    running,
    output logic    frozen,
    output logic    overflow,
    output logic    ready
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = cnt_width(DIV);

    if (CLK_HZ % TICK_HZ != 0) begin : g_bad_div
        $error("CLK_HZ must be an integer multiple of TICK_HZ");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic             w_start;
    logic             w_lap_raw;
    logic             w_lap;
    logic             w_run;
    logic             w_tick;
    logic             w_clear;
    logic [8:0]       w_carry;
    chrono_t          w_next;
    logic [0:0]       r_state;
    logic             r_frozen;
    logic             r_overflow;
    logic             r_ready;
    logic [PRE_W-1:0] r_pre;
    chrono_t          r_live;
    chrono_t          r_split;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn_start),
        .level    (),
        .released (w_start)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn_lap),
        .level    (),
        .released (w_lap_raw)
    );

    // Start wins over a coincident lap
    assign w_lap   = w_lap_raw & ~w_start;
    assign w_run   = r_state == ST_RUNNING;
    assign w_tick  = w_run && r_pre == PRE_W'(DIV - 1);
    assign w_clear = w_lap && !w_run && !r_frozen;

    // Ripple carry: a digit moves only when every lower digit sits at its limit on a tick
    assign w_carry[0] = w_tick;
    for (genvar d = 0; d < 8; d++) begin : g_dig
        logic w_lim;
        assign w_lim        = r_live[d] == DIGIT_LIMIT[d];
        assign w_carry[d+1] = w_carry[d] & w_lim;
        assign w_next[d]    = !w_carry[d] ? r_live[d] : w_lim ? bcd_t'(0) : r_live[d] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_STOPPED;
            r_frozen   <= 1'b0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
            r_pre      <= '0;
            r_split    <= '0;
        end else begin
            r_ready <= 1'b1;
            if (w_start) r_state <= w_run ? ST_STOPPED : ST_RUNNING;
            if (w_lap) r_frozen <= w_run ? !r_frozen : 1'b0;
            if (w_lap && w_run && !r_frozen) r_split <= r_live;
            if (w_clear) begin
                r_pre      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_run) r_pre <= w_tick ? '0 : r_pre + 1'b1;
                if (w_carry[8]) r_overflow <= 1'b1;
            end
        end
    end

    // Live digits are only written on a tick or a clear, so they hold otherwise
    always_ff @(posedge clk) begin
        if (rst || w_clear) r_live <= '0;
        else if (w_tick) r_live <= w_next;
    end

    assign value    = r_frozen ? r_split : r_live;
    assign running  = w_run;
    assign frozen   = r_frozen;
    assign overflow = r_overflow;
    assign ready    = r_ready;
endmodule

// File: tb/tb_chrono_lap_core.sv
// tb_chrono_lap_core: directed checks of debounce, counting, pause, lap, clear and wrap
module tb_chrono_lap_core;
    import chrono_pkg::*;
    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    btn_start = 1'b0;
    logic    btn_lap = 1'b0;
    chrono_t value;
    logic    running;
    logic    frozen;
    logic    overflow;
    logic    ready;
    int      n_chk = 0;
    int      n_fail = 0;

    chrono_lap_core #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .value     (value),
        .running   (running),
        .frozen    (frozen),
        .overflow  (overflow),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 10 cycles pressed, then 7 cycles so the action has just been applied (17 edges in all)
    task automatic press(input logic s, input logic l);
        btn_start = s;
        btn_lap   = l;
        cyc(10);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        cyc(7);
    endtask

    initial begin
        cyc(3);
        chk("rst_value", value, 32'h0);
        chk("rst_flags", {28'h0, running, frozen, overflow, ready}, 32'h0);
        rst = 1'b0;
        cyc(1);
        chk("ready", {31'h0, ready}, 32'h1);
        btn_start = 1'b1;
        cyc(3);
        btn_start = 1'b0;
        cyc(12);
        chk("glitch", {31'h0, running}, 32'h0);
        btn_start = 1'b1;
        cyc(10);
        btn_start = 1'b0;
        cyc(6);
        chk("start_lat6", {31'h0, running}, 32'h0);
        cyc(1);
        chk("start_lat7", {31'h0, running}, 32'h1);
        cyc(250);
        chk("count_25", value, 32'h0000_0025);
        cyc(69);
        press(1'b1, 1'b0);
        chk("pause_run", {31'h0, running}, 32'h0);
        chk("pause_val", value, 32'h0000_0033);
        cyc(500);
        chk("pause_hold", value, 32'h0000_0033);
        press(1'b1, 1'b0);
        cyc(3);
        chk("resume_3", value, 32'h0000_0033);
        cyc(1);
        chk("resume_4", value, 32'h0000_0034);
        cyc(848);
        press(1'b0, 1'b1);
        chk("lap_frozen", {31'h0, frozen}, 32'h1);
        chk("lap_val", value, 32'h0000_0120);
        cyc(100);
        chk("lap_hold", value, 32'h0000_0120);
        chk("lap_still_run", {31'h0, running}, 32'h1);
        cyc(733);
        press(1'b0, 1'b1);
        chk("unlap_frozen", {31'h0, frozen}, 32'h0);
        chk("unlap_val", value, 32'h0000_0205);
        press(1'b1, 1'b0);
        chk("stop_val", value, 32'h0000_0207);
        press(1'b0, 1'b1);
        chk("clear_val", value, 32'h0);
        chk("clear_ovf", {31'h0, overflow}, 32'h0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("lap2_val", value, 32'h0000_0001);
        press(1'b1, 1'b0);
        chk("stopfz_flags", {30'h0, running, frozen}, 32'h1);
        chk("stopfz_val", value, 32'h0000_0001);
        press(1'b0, 1'b1);
        chk("unfz_flag", {31'h0, frozen}, 32'h0);
        chk("unfz_val", value, 32'h0000_0003);
        press(1'b0, 1'b1);
        chk("clear2_val", value, 32'h0);
        force dut.r_live = 32'h9959_5999;
        cyc(1);
        release dut.r_live;
        cyc(1);
        chk("preset_val", value, 32'h9959_5999);
        press(1'b1, 1'b0);
        cyc(9);
        chk("prewrap_val", value, 32'h9959_5999);
        chk("prewrap_ovf", {31'h0, overflow}, 32'h0);
        cyc(1);
        chk("wrap_val", value, 32'h0);
        chk("wrap_ovf", {31'h0, overflow}, 32'h1);
        press(1'b0, 1'b1);
        chk("fz_before_both", {31'h0, frozen}, 32'h1);
        press(1'b1, 1'b1);
        chk("both_flags", {30'h0, running, frozen}, 32'h1);
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);
        press(1'b0, 1'b1);
        chk("unfz_ovf_kept", {30'h0, frozen, overflow}, 32'h1);
        press(1'b0, 1'b1);
        chk("clear3_ovf", {31'h0, overflow}, 32'h0);
        chk("clear3_val", value, 32'h0);
        btn_start = 1'b1;
        cyc(10);
        btn_start = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        chk("midrst_flags", {30'h0, running, ready}, 32'h0);
        rst = 1'b0;
        cyc(12);
        chk("midrst_drop", {30'h0, running, ready}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
